// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide sequencer: shift-add multiply, restoring divide, RISC-V M fixups.
// Define MULDIV_EARLY_OUT_EN to let zero-operand multiplies and zero-dividend divides skip RUN.
module muldiv_sequencer #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            mul_start,
  input  logic            div_start,
  input  logic            div_sign,
  input  logic            sel_rem,
  input  logic            word,
  input  logic            flush,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned HalfW = XLEN / 2;
  localparam int unsigned CntW  = $clog2(XLEN);
  localparam logic [CntW-1:0]  CntFull = CntW'(XLEN - 1);
  localparam logic [CntW-1:0]  CntHalf = CntW'(HalfW - 1);
  localparam logic [XLEN-1:0]  MinFull = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [HalfW-1:0] MinHalf = {1'b1, {(HalfW-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StRun, StFix, StDone} state_e;

  state_e state_q, state_d;
  logic [XLEN-1:0] acc_q, acc_d, opa_q, opa_d, opb_q, opb_d, result_q, result_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic is_mul_q, is_mul_d, sel_rem_q, sel_rem_d, word_q, word_d;
  logic dz_q, dz_d, ovf_q, ovf_d, q_neg_q, q_neg_d, r_neg_q, r_neg_d;

  // Start-side operand decode
  logic            start_any, start_div, accept;
  logic [XLEN-1:0] ext_a, ext_b, mag_a, mag_b;
  logic            a_zero, b_zero, neg_a, neg_b, ovf_hit, bypass, early;

  always_comb begin
    start_any = mul_start | div_start;
    start_div = div_start & ~mul_start;
    accept    = start_any & ~flush;
    if (word) begin
      ext_a = div_sign ? {{HalfW{src_a[HalfW-1]}}, src_a[HalfW-1:0]}
                       : {{HalfW{1'b0}}, src_a[HalfW-1:0]};
      ext_b = div_sign ? {{HalfW{src_b[HalfW-1]}}, src_b[HalfW-1:0]}
                       : {{HalfW{1'b0}}, src_b[HalfW-1:0]};
    end else begin
      ext_a = src_a;
      ext_b = src_b;
    end
    a_zero  = ~|ext_a;
    b_zero  = ~|ext_b;
    neg_a   = start_div & div_sign & ext_a[XLEN-1];
    neg_b   = start_div & div_sign & ext_b[XLEN-1];
    mag_a   = neg_a ? -ext_a : ext_a;
    mag_b   = neg_b ? -ext_b : ext_b;
    ovf_hit = start_div & div_sign &
              (word ? ((src_a[HalfW-1:0] == MinHalf) & (&src_b[HalfW-1:0]))
                    : ((src_a == MinFull) & (&src_b)));
    bypass  = (start_div & b_zero) | ovf_hit;
`ifdef MULDIV_EARLY_OUT_EN
    early   = mul_start ? (a_zero | b_zero) : (start_div & a_zero);
`else
    early   = 1'b0;
`endif
  end

  // One iteration of either algorithm
  logic [XLEN:0]   trial, diff;
  logic            sub_ok;
  logic [XLEN-1:0] mul_sum;

  always_comb begin
    trial   = {acc_q, opa_q[XLEN-1]};
    diff    = trial - {1'b0, opb_q};
    sub_ok  = ~diff[XLEN];
    mul_sum = acc_q + (opb_q[0] ? opa_q : '0);
  end

  // Final sign/corner-case fixup
  logic [XLEN-1:0] q_fix, r_fix, sel_val, fix_val;

  always_comb begin
    if (dz_q) begin
      q_fix = '1;
      r_fix = opa_q;
    end else if (ovf_q) begin
      q_fix = opa_q;
      r_fix = '0;
    end else begin
      q_fix = q_neg_q ? -opa_q : opa_q;
      r_fix = r_neg_q ? -acc_q : acc_q;
    end
    sel_val = is_mul_q ? acc_q : (sel_rem_q ? r_fix : q_fix);
    fix_val = word_q ? {{HalfW{sel_val[HalfW-1]}}, sel_val[HalfW-1:0]} : sel_val;
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    is_mul_d  = is_mul_q;
    sel_rem_d = sel_rem_q;
    word_d    = word_q;
    dz_d      = dz_q;
    ovf_d     = ovf_q;
    q_neg_d   = q_neg_q;
    r_neg_d   = r_neg_q;
    stall     = 1'b0;
    unique case (state_q)
      StIdle: begin
        stall = accept;
        if (accept) begin
          is_mul_d  = mul_start;
          sel_rem_d = sel_rem;
          word_d    = word;
          dz_d      = start_div & b_zero;
          ovf_d     = ovf_hit;
          q_neg_d   = neg_a ^ neg_b;
          r_neg_d   = neg_a;
          cnt_d     = word ? CntHalf : CntFull;
          acc_d     = '0;
          if (mul_start || bypass) begin
            opa_d = ext_a;
            opb_d = ext_b;
          end else begin
            // Word divides start with the dividend in the upper half so its MSB shifts out first
            opa_d = word ? {mag_a[HalfW-1:0], {HalfW{1'b0}}} : mag_a;
            opb_d = mag_b;
          end
          state_d = (bypass || early) ? StFix : StRun;
        end
      end
      StRun: begin
        stall = 1'b1;
        if (is_mul_q) begin
          acc_d = mul_sum;
          opa_d = opa_q << 1;
          opb_d = opb_q >> 1;
        end else begin
          acc_d = sub_ok ? diff[XLEN-1:0] : trial[XLEN-1:0];
          opa_d = {opa_q[XLEN-2:0], sub_ok};
        end
        if (cnt_q == '0) begin
          state_d = StFix;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StFix: begin
        stall    = 1'b1;
        result_d = fix_val;
        state_d  = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (flush) begin
      state_d  = StIdle;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= StIdle;
      acc_q     <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      is_mul_q  <= 1'b0;
      sel_rem_q <= 1'b0;
      word_q    <= 1'b0;
      dz_q      <= 1'b0;
      ovf_q     <= 1'b0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      is_mul_q  <= is_mul_d;
      sel_rem_q <= sel_rem_d;
      word_q    <= word_d;
      dz_q      <= dz_d;
      ovf_q     <= ovf_d;
      q_neg_q   <= q_neg_d;
      r_neg_q   <= r_neg_d;
    end
  end

  assign done   = (state_q == StDone) & ~flush;
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed corner cases plus random ops
// checked against an arithmetic reference of RISC-V M semantics.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        resetn;
  logic        mul_start, div_start, div_sign, sel_rem, word, flush;
  logic [63:0] src_a, src_b;
  logic        stall, done;
  logic [63:0] result;

  int compared   = 0;
  int mismatched = 0;

  muldiv_sequencer #(.XLEN(64)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .mul_start (mul_start),
    .div_start (div_start),
    .div_sign  (div_sign),
    .sel_rem   (sel_rem),
    .word      (word),
    .flush     (flush),
    .src_a     (src_a),
    .src_b     (src_b),
    .stall     (stall),
    .done      (done),
    .result    (result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  function automatic logic [63:0] ref_result(input bit m, input bit sg, input bit rm, input bit wd,
                                             input logic [63:0] a, input logic [63:0] b);
    logic [63:0] p, q64, r64;
    logic [31:0] a32, b32, q32, r32;
    int          sa, sb;
    longint      la, lb;
    if (m) begin
      p = a * b;
      return wd ? sext32(p[31:0]) : p;
    end
    if (wd) begin
      a32 = a[31:0];
      b32 = b[31:0];
      sa  = a32;
      sb  = b32;
      if (b32 == 32'd0) begin
        q32 = 32'hFFFF_FFFF; r32 = a32;
      end else if (sg && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
        q32 = a32; r32 = 32'd0;
      end else if (sg) begin
        q32 = sa / sb; r32 = sa % sb;
      end else begin
        q32 = a32 / b32; r32 = a32 % b32;
      end
      return sext32(rm ? r32 : q32);
    end
    la = a;
    lb = b;
    if (b == 64'd0) begin
      q64 = 64'hFFFF_FFFF_FFFF_FFFF; r64 = a;
    end else if (sg && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) begin
      q64 = a; r64 = 64'd0;
    end else if (sg) begin
      q64 = la / lb; r64 = la % lb;
    end else begin
      q64 = a / b; r64 = a % b;
    end
    return rm ? r64 : q64;
  endfunction

  function automatic int ref_latency(input bit m, input bit sg, input bit wd,
                                     input logic [63:0] a, input logic [63:0] b);
    bit az, bz, ov;
    az = wd ? (a[31:0] == 32'd0) : (a == 64'd0);
    bz = wd ? (b[31:0] == 32'd0) : (b == 64'd0);
    ov = sg && (wd ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                   : (a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF));
    if (!m && (bz || ov)) return 2;
`ifdef MULDIV_EARLY_OUT_EN
    if (m && (az || bz)) return 2;
    if (!m && az) return 2;
`endif
    return wd ? 34 : 66;
  endfunction

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 7))
      0: return 64'd0;
      1: return 64'hFFFF_FFFF_FFFF_FFFF;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'hFFFF_FFFF_8000_0000;
      4: return 64'($urandom_range(0, 20));
      5: return -64'($urandom_range(1, 20));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // Issue one op, then scramble all inputs (including stray starts) while it runs.
  task automatic run_op(input string tag, input bit m, input bit d, input bit sg, input bit rm,
                        input bit wd, input logic [63:0] a, input logic [63:0] b);
    logic [63:0] exp;
    int          lat, got_k;
    bit          stall_ok;
    exp      = ref_result(m, sg, rm, wd, a, b);
    lat      = ref_latency(m, sg, wd, a, b);
    got_k    = 0;
    stall_ok = 1'b1;
    @(posedge clk); #1;
    mul_start = m; div_start = d; div_sign = sg; sel_rem = rm; word = wd;
    src_a = a; src_b = b; flush = 1'b0;
    #1 chk({tag, "_stall_start"}, 64'(stall), 64'd1);
    @(posedge clk); #1;
    for (int k = 1; k <= 100; k++) begin
      mul_start = ($urandom_range(0, 7) == 0);
      div_start = ($urandom_range(0, 7) == 0);
      div_sign  = 1'($urandom);
      sel_rem   = 1'($urandom);
      word      = 1'($urandom);
      src_a     = {$urandom, $urandom};
      src_b     = {$urandom, $urandom};
      @(negedge clk);
      if (done === 1'b1) begin
        got_k = k;
        break;
      end
      if (stall !== 1'b1) stall_ok = 1'b0;
      @(posedge clk); #1;
    end
    mul_start = 1'b0; div_start = 1'b0;
    chk({tag, "_latency"}, 64'(got_k), 64'(lat));
    chk({tag, "_result"}, result, exp);
    chk({tag, "_stall_busy"}, 64'(stall_ok), 64'd1);
    chk({tag, "_stall_done"}, 64'(stall), 64'd0);
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, 64'(done), 64'd0);
    chk({tag, "_result_hold"}, result, exp);
  endtask

  initial begin
    logic [63:0] prev;
    bit          saw_done;
    resetn = 1'b0; mul_start = 1'b0; div_start = 1'b0; div_sign = 1'b0;
    sel_rem = 1'b0; word = 1'b0; flush = 1'b0; src_a = '0; src_b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_stall", 64'(stall), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_result", result, 64'd0);
    resetn = 1'b1;

    run_op("sdiv_q", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 64'd7, -64'd2);
    chk("sdiv_q_value", result, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op("srem", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 64'd7, -64'd2);
    chk("srem_value", result, 64'd1);
    run_op("mulw", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 64'h7FFF_FFFF, 64'd2);
    chk("mulw_value", result, 64'hFFFF_FFFF_FFFF_FFFE);
    run_op("divuw_z_q", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 64'd5, 64'd0);
    run_op("remuw_z", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 64'd5, 64'd0);
    chk("remuw_z_value", result, 64'd5);
    run_op("ovf_q", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, -64'd1);
    run_op("ovf_r", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 64'h8000_0000_0000_0000, -64'd1);
    run_op("mul_wins", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 64'd9, 64'd11);
    run_op("mul_zero", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 64'd1234);
    run_op("div_zero_dvd", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 64'd0, 64'd3);

    // Start and flush in the same idle cycle: start dropped
    @(posedge clk); #1;
    div_start = 1'b1; flush = 1'b1; src_a = 64'd100; src_b = 64'd7;
    #1 chk("start_flush_stall", 64'(stall), 64'd0);
    @(posedge clk); #1;
    div_start = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("start_flush_idle", 64'(stall), 64'd0);

    // Flush at cycle 10 of a 64-bit divide
    prev = result;
    @(posedge clk); #1;
    div_start = 1'b1; div_sign = 1'b0; sel_rem = 1'b0; word = 1'b0;
    src_a = 64'd1000; src_b = 64'd7;
    @(posedge clk); #1;
    div_start = 1'b0;
    for (int k = 2; k <= 10; k++) begin
      @(posedge clk); #1;
    end
    flush = 1'b1;
    @(negedge clk);
    chk("flush_c10_stall", 64'(stall), 64'd1);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_c11_stall", 64'(stall), 64'd0);
    chk("flush_c11_done", 64'(done), 64'd0);
    saw_done = 1'b0;
    for (int k = 0; k < 70; k++) begin
      @(negedge clk);
      saw_done = saw_done | done;
    end
    chk("flush_no_done", 64'(saw_done), 64'd0);
    chk("flush_result_kept", result, prev);
    run_op("after_flush_mul", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'd3, 64'd4);
    chk("after_flush_value", result, 64'd12);

    // Reset mid-RUN
    @(posedge clk); #1;
    div_start = 1'b1; src_a = 64'd77; src_b = 64'd5;
    @(posedge clk); #1;
    div_start = 1'b0;
    repeat (5) @(posedge clk);
    #1 resetn = 1'b0;
    #1;
    chk("midrst_stall", 64'(stall), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_result", result, 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    run_op("after_rst_div", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 64'd77, 64'd5);

    for (int i = 0; i < 30; i++) begin
      bit m, d;
      m = ($urandom_range(0, 2) == 0);
      d = !m || ($urandom_range(0, 1) == 1);
      run_op($sformatf("rand%0d", i), m, d, 1'($urandom), 1'($urandom), 1'($urandom),
             pick(), pick());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
